rdy_halt_ctrl: RTL and testbench
================================

Name: rdy_halt_ctrl

Overview:
- Bus-side counterpart of the CPU control FSM's RDY/SYNC interface. The CPU FSM consumes RDY and emits SYNC; this block generates RDY.
- Halts the 6502C core for two reasons: WSYNC (wait for a fixed horizontal position) and DMA bursts (bus handed to DMA for N cycles).
- Owns a free-running horizontal machine-cycle counter.
- RDY is only pulled low after a sampled read cycle, because the core ignores RDY on writes.

Parameters:
- HCOUNT_W, 7, width of horizontal cycle counter
- HLINE_LEN, 114, machine cycles per line; counter wraps at HLINE_LEN-1
- WSYNC_POS, 105, hcount value at which a pending WSYNC releases

Ports:
- phi2  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- RW  in  1  current CPU cycle type, 1=read, 0=write
- SYNC  in  1  CPU opcode-fetch cycle indicator
- wsync_wr  in  1  single-cycle pulse: CPU wrote the WSYNC register
- dma_req  in  1  single-cycle pulse: request a DMA burst
- dma_len  in  4  burst length in cycles, sampled with dma_req; 0 means 16
- RDY  out  1  registered ready to CPU; 0 = halt
- dma_grant  out  1  registered; 1 in each cycle the bus belongs to DMA
- dma_drop  out  1  registered one-cycle pulse: dma_req discarded
- busy  out  1  state != IDLE
- hcount  out  HCOUNT_W  horizontal cycle counter

Behaviour:
- Reset (async): RDY=1, dma_grant=0, dma_drop=0, busy=0, hcount=0, state=IDLE, all pend flags and counters cleared. Reset asserted mid-burst or mid-wait takes effect immediately, with no completion of the burst.
- hcount: increments every edge; HLINE_LEN-1 -> 0.
- wsync_pend:
  - set by wsync_wr.
  - cleared at the edge where sampled hcount==WSYNC_POS, in any state.
  - If set and clear occur on the same edge, set wins, so the wait lasts a full line.
  - wsync_wr while already pending: no effect.
- dma_pend/dma_cnt:
  - dma_req in IDLE, ARM or WAIT latches dma_pend=1 and the length.
  - dma_req while dma_pend=1 or state=DMA: request dropped, dma_drop=1 for one cycle, no other effect.
- States:
  - IDLE: RDY=1. Any pend flag set (including one set this edge) -> ARM.
  - ARM: RDY=1; waits indefinitely. Sampled RW=1 -> HALT (RDY=0 from this edge). RW=0 -> stay.
  - HALT: RDY=0. Priority dma_pend -> DMA (load dma_cnt, grant=1, clear dma_pend); else wsync_pend -> WAIT; else -> IDLE (RDY=1).
  - DMA: RDY=0, grant=1. dma_cnt decrements each edge; at dma_cnt==1 -> HALT, grant=0. Grant is high for exactly len cycles.
  - WAIT: RDY=0. A new dma_pend -> HALT, then DMA; wsync_pend stays pending. wsync_pend cleared -> HALT.
- If WSYNC_POS passes during DMA, the WSYNC is released. The return goes through HALT, then IDLE, with no extra line wait.
- Minimum latency from a request pulse to RDY=0 is 2 edges: the request edge, then the ARM edge with RW=1.
- RDY recovery: 1 HALT cycle after the last grant or release, then IDLE.

Optional Feature:
- RDY_SYNC_ALIGN_EN defined:
  - ARM->HALT requires RW=1 and SYNC=1, so halts land only on opcode fetch, matching the CPU FSM stall-on-fetch state.
  - ARM otherwise waits.
- Not defined: ARM->HALT on RW=1 alone; SYNC is ignored.

Test Plan:
- Reset release, no requests, 228 edges -> RDY=1, grant=0, busy=0 throughout; hcount 0..113 twice, returns to 0.
- RW=1 constant; dma_req with len=3 at edge 10 ->
  - ARM at 10; RDY=0 from edge 11.
  - grant=1 after edges 12, 13 and 14; grant=0 at 15.
  - RDY=1 at edge 16.
- dma_req len=1 while RW=0 for 3 cycles, then RW=1 -> ARM held 3 edges; RDY falls on the first edge sampling RW=1; grant pulses exactly 1 cycle.
- wsync_wr at hcount=20, RW=1 ->
  - RDY=0 two edges later.
  - Remains 0 until the edge sampling hcount=105 (-> HALT).
  - RDY=1 at the following edge.
- wsync_wr on the edge sampling hcount=105 -> no release this line; release at hcount=105 of the next line (114 cycles later).
- Overlap and reset:
  - Second dma_req during DMA -> dma_drop=1 for one cycle; grant count unchanged.
  - Reset asserted mid-DMA -> RDY=1 and grant=0 immediately, busy=0.
  - With RDY_SYNC_ALIGN_EN and RW=1 but SYNC=0 -> remains in ARM, RDY=1.

Source files
------------

// File: rtl/rdy_halt_ctrl_if.sv
// rdy_halt_ctrl_if: CPU/bus-side handshake between the core, the bus and the RDY halt controller
interface rdy_halt_ctrl_if #(parameter int HCOUNT_W = 7);
    logic                RW;
    logic                SYNC;
    logic                wsync_wr;
    logic                dma_req;
    logic [3:0]          dma_len;
    logic                RDY;
    logic                dma_grant;
    logic                dma_drop;
    logic                busy;
    logic [HCOUNT_W-1:0] hcount;
    modport master(output RW, SYNC, wsync_wr, dma_req, dma_len,
                   input RDY, dma_grant, dma_drop, busy, hcount);
    modport slave(input RW, SYNC, wsync_wr, dma_req, dma_len,
                  output RDY, dma_grant, dma_drop, busy, hcount);
endinterface

// File: rtl/rdy_halt_ctrl.sv
// rdy_halt_ctrl: generates 6502C RDY for WSYNC waits and DMA bursts; owns the horizontal cycle counter.
// Optional RDY_SYNC_ALIGN_EN: halts only land on opcode-fetch read cycles (RW=1 and SYNC=1).
module rdy_halt_ctrl #(
    parameter int HCOUNT_W  = 7,
    parameter int HLINE_LEN = 114,
    parameter int WSYNC_POS = 105
) (
    input  logic            phi2,
    input  logic            reset,
    rdy_halt_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ARM, HALT, DMA, WAIT} state_t;
    localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(HLINE_LEN - 1);
    localparam logic [HCOUNT_W-1:0] H_REL  = HCOUNT_W'(WSYNC_POS);
    state_t              state, state_nxt;
    logic [HCOUNT_W-1:0] hcount;
    logic                wsync_pend, wsync_nxt;
    logic                dma_pend, dma_pend_nxt;
    logic [4:0]          dma_len_q, dma_cnt, cnt_nxt;
    logic                dma_hit, dma_take, arm_go;
    logic                rdy, grant, drop;
`ifdef RDY_SYNC_ALIGN_EN
    assign arm_go = bus.RW & bus.SYNC;
`else
    logic unused_sync;
    assign unused_sync = bus.SYNC;
    assign arm_go      = bus.RW;
`endif
    // a write on the release edge wins, so the wait spans a full line
    assign wsync_nxt = bus.wsync_wr | (wsync_pend & (hcount != H_REL));
    assign dma_hit   = bus.dma_req & (dma_pend | (state == DMA));
    assign dma_take  = bus.dma_req & ~dma_hit;
    always_comb begin
        state_nxt    = state;
        dma_pend_nxt = dma_pend | dma_take;
        cnt_nxt      = dma_cnt;
        case (state)
            IDLE: state_nxt = (wsync_nxt | dma_pend_nxt) ? ARM : IDLE;
            ARM:  state_nxt = arm_go ? HALT : ARM;
            HALT: begin
                if (dma_pend) begin
                    state_nxt    = DMA;
                    cnt_nxt      = dma_len_q;
                    dma_pend_nxt = 1'b0;
                end else begin
                    state_nxt = wsync_nxt ? WAIT : IDLE;
                end
            end
            DMA: begin
                cnt_nxt   = dma_cnt - 5'd1;
                state_nxt = (dma_cnt == 5'd1) ? HALT : DMA;
            end
            WAIT:    state_nxt = (dma_pend | ~wsync_nxt) ? HALT : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hcount     <= '0;
            wsync_pend <= 1'b0;
            dma_pend   <= 1'b0;
            dma_len_q  <= '0;
            dma_cnt    <= '0;
            rdy        <= 1'b1;
            grant      <= 1'b0;
            drop       <= 1'b0;
        end else begin
            state      <= state_nxt;
            hcount     <= (hcount == H_LAST) ? '0 : hcount + 1'b1;
            wsync_pend <= wsync_nxt;
            dma_pend   <= dma_pend_nxt;
            dma_len_q  <= dma_take ? {bus.dma_len == 4'd0, bus.dma_len} : dma_len_q;
            dma_cnt    <= cnt_nxt;
            rdy        <= (state_nxt == IDLE) | (state_nxt == ARM);
            grant      <= state_nxt == DMA;
            drop       <= dma_hit;
        end
    end
    assign bus.RDY       = rdy;
    assign bus.dma_grant = grant;
    assign bus.dma_drop  = drop;
    assign bus.busy      = state != IDLE;
    assign bus.hcount    = hcount;
endmodule

// File: tb/tb_rdy_halt_ctrl.sv
// tb_rdy_halt_ctrl: directed vectors with a scoreboard queue checked by an independent monitor.
module tb_rdy_halt_ctrl;
    typedef struct packed {
        logic [3:0] e;
        logic [6:0] h;
    } exp_t;
    localparam logic [3:0] E_IDLE = 4'b1000;
    localparam logic [3:0] E_ARM  = 4'b1001;
    localparam logic [3:0] E_HOLD = 4'b0001;
    localparam logic [3:0] E_DMA  = 4'b0101;
    localparam logic [3:0] E_DROP = 4'b0111;
    logic phi2 = 1'b0;
    logic reset = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    logic [6:0] exp_h = '0;
    exp_t sb[$];
    rdy_halt_ctrl_if #(.HCOUNT_W(7)) bus();
    rdy_halt_ctrl #(.HCOUNT_W(7), .HLINE_LEN(114), .WSYNC_POS(105)) dut (
        .phi2(phi2),
        .reset(reset),
        .bus(bus)
    );
    always #5 phi2 = ~phi2;
    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction
    function automatic logic [10:0] got();
        return {bus.RDY, bus.dma_grant, bus.dma_drop, bus.busy, bus.hcount};
    endfunction
    always @(posedge phi2) begin
        #1;
        if (!reset && sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk("cycle {rdy,gnt,drop,busy,hcount}", 32'(got()), 32'(x));
        end
    end
    // called at a negedge; expectation is for the state after the next posedge
    task automatic step(input logic rw, sync, wr, req, input logic [3:0] len, input logic [3:0] e);
        bus.RW = rw;
        bus.SYNC = sync;
        bus.wsync_wr = wr;
        bus.dma_req = req;
        bus.dma_len = len;
        exp_h = (exp_h == 7'd113) ? 7'd0 : exp_h + 7'd1;
        sb.push_back('{e, exp_h});
        @(negedge phi2);
    endtask
    task automatic hold(input int n, input logic [3:0] e);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, e);
    endtask
    task automatic idle_until(input logic [6:0] h);
        while (exp_h != h) step(1, 0, 0, 0, 0, E_IDLE);
    endtask
    task automatic release_reset();
        @(negedge phi2);
        reset = 1'b0;
        exp_h = '0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
    initial begin
        bus.RW = 1'b1;
        bus.SYNC = 1'b0;
        bus.wsync_wr = 1'b0;
        bus.dma_req = 1'b0;
        bus.dma_len = 4'd0;
        @(negedge phi2);
        @(negedge phi2);
        chk("reset state", 32'(got()), {21'd0, E_IDLE, 7'd0});
        release_reset();
        hold(228, E_IDLE);
        // dma len=3 with RW=1
        step(1, 0, 0, 1, 4'd3, E_ARM);
        hold(1, E_HOLD);
        hold(3, E_DMA);
        hold(1, E_HOLD);
        hold(1, E_IDLE);
        // dma len=1 while RW=0 holds ARM
        step(0, 0, 0, 1, 4'd1, E_ARM);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, E_ARM);
        hold(1, E_HOLD);
        hold(1, E_DMA);
        hold(1, E_HOLD);
        hold(1, E_IDLE);
        // wsync at hcount 20 releases at 105
        idle_until(7'd20);
        step(1, 0, 1, 0, 0, E_ARM);
        hold(1, E_HOLD);
        while (exp_h != 7'd105) hold(1, E_HOLD);
        hold(1, E_HOLD);
        hold(1, E_IDLE);
        // wsync written on the release edge waits a full line
        idle_until(7'd105);
        step(1, 0, 1, 0, 0, E_ARM);
        hold(1, E_HOLD);
        while (exp_h != 7'd105) hold(1, E_HOLD);
        hold(1, E_HOLD);
        hold(1, E_IDLE);
        // second request during DMA is dropped, burst length unchanged
        step(1, 0, 0, 1, 4'd4, E_ARM);
        hold(1, E_HOLD);
        hold(1, E_DMA);
        step(1, 0, 0, 1, 4'd2, E_DROP);
        hold(2, E_DMA);
        hold(1, E_HOLD);
        hold(1, E_IDLE);
        // request while pending is dropped; first length kept
        step(0, 0, 0, 1, 4'd2, E_ARM);
        step(0, 0, 0, 1, 4'd5, 4'b1011);
        hold(1, E_HOLD);
        hold(2, E_DMA);
        hold(1, E_HOLD);
        hold(1, E_IDLE);
        // len=0 means 16
        step(1, 0, 0, 1, 4'd0, E_ARM);
        hold(1, E_HOLD);
        hold(16, E_DMA);
        hold(1, E_HOLD);
        hold(1, E_IDLE);
        // DMA from WAIT spanning the release point returns straight to IDLE
        idle_until(7'd40);
        step(1, 0, 1, 0, 0, E_ARM);
        hold(1, E_HOLD);
        while (exp_h != 7'd103) hold(1, E_HOLD);
        step(1, 0, 0, 1, 4'd4, E_HOLD);
        hold(1, E_HOLD);
        hold(4, E_DMA);
        hold(1, E_HOLD);
        hold(1, E_IDLE);
`ifdef RDY_SYNC_ALIGN_EN
        step(1, 0, 0, 1, 4'd2, E_ARM);
        hold(3, E_ARM);
        step(1, 1, 0, 0, 0, E_HOLD);
`else
        step(1, 0, 0, 1, 4'd2, E_ARM);
        hold(1, E_HOLD);
`endif
        hold(2, E_DMA);
        hold(1, E_HOLD);
        hold(1, E_IDLE);
        // async reset mid-burst
        step(1, 0, 0, 1, 4'd8, E_ARM);
        hold(1, E_HOLD);
        hold(2, E_DMA);
        #2 reset = 1'b1;
        #1 chk("async reset mid-DMA", 32'(got()), {21'd0, E_IDLE, 7'd0});
        @(negedge phi2);
        release_reset();
        hold(12, E_IDLE);
        @(negedge phi2);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
